// File: rtl/bank_pkg.sv
// bank_pkg: shared definitions for the bank-conflict serializer.
//   - default parameter values for lanes, banks, address/data/warp widths
//   - BANK_LOG for the default bank count
//   - serState_t, the serializer FSM state type
//   - wordOf()/bankOf(): pull the word index and bank index out of a byte address
// Addresses are zero-extended to MAX_ADDR_W before extraction. This lets one
// pair of helpers serve any ADDR_W up to MAX_ADDR_W.
package bank_pkg;

  localparam int DEF_NUM_LANES = 32;
  localparam int DEF_NUM_BANKS = 16;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_WARP_LOG  = 5;

  localparam int BANK_LOG   = $clog2(DEF_NUM_BANKS);
  localparam int MAX_ADDR_W = 64;

  typedef enum logic {
    IDLE,
    ISSUE
  } serState_t;

  // Word index: the byte address with the in-word offset bits [1:0] dropped.
  function automatic logic [MAX_ADDR_W-1:0] wordOf(input logic [MAX_ADDR_W-1:0] addr);
    return addr >> 2;
  endfunction

  // Bank index: the low bankLog bits of the word index.
  function automatic logic [MAX_ADDR_W-1:0] bankOf(input logic [MAX_ADDR_W-1:0] addr,
                                                   input int                    bankLog);
    return (addr >> 2) & ((MAX_ADDR_W'(1) << bankLog) - MAX_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/bank_lane_select.sv
// bank_lane_select: combinational lane picker for one serializer pass.
//   pending  : lanes still waiting to be issued
//   laneAddr : per-lane byte addresses, lane 0 at the LSBs
//   isLoad   : 1 = load (same-word lanes share the bank access), 0 = store
//   passMask : lanes issued on this pass
// In each bank, the lowest-indexed pending lane wins. A load also carries
// every pending lane that reads the winner's word (broadcast). A store
// carries only the winner. Same-address stores therefore go out in
// ascending lane order.
module bank_lane_select
  import bank_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic [NUM_LANES-1:0]        pending,
  input  logic [NUM_LANES*ADDR_W-1:0] laneAddr,
  input  logic                        isLoad,
  output logic [NUM_LANES-1:0]        passMask
);

  localparam int BL     = $clog2(NUM_BANKS);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic [BL-1:0]         laneBank [NUM_LANES];
  logic [MAX_ADDR_W-1:0] laneWord [NUM_LANES];
  logic [LANE_W-1:0]     winLane  [NUM_BANKS];
  logic [MAX_ADDR_W-1:0] winWord  [NUM_BANKS];

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      laneBank[i] = BL'(bankOf(MAX_ADDR_W'(laneAddr[i*ADDR_W +: ADDR_W]), BL));
      laneWord[i] = wordOf(MAX_ADDR_W'(laneAddr[i*ADDR_W +: ADDR_W]));
    end
  end

  // Walk the lanes from highest to lowest so the lowest pending lane writes
  // last and wins its bank.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // write; a path that leaves a variable unassigned would infer a latch.
    for (int b = 0; b < NUM_BANKS; b++) begin
      winLane[b] = '0;
      winWord[b] = '0;
    end
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winLane[laneBank[i]] = LANE_W'(i);
        winWord[laneBank[i]] = laneWord[i];
      end
    end
  end

  // A pending lane always has a winner in its bank, because in the worst
  // case it is that winner. No per-bank valid bit is needed.
  always_comb begin
    passMask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (isLoad) begin
        passMask[i] = pending[i] && (laneWord[i] == winWord[laneBank[i]]);
      end else begin
        passMask[i] = pending[i] && (winLane[laneBank[i]] == LANE_W'(i));
      end
    end
  end

endmodule

// File: rtl/bank_conflict_serializer.sv
// bank_conflict_serializer: splits one warp memory packet into passes that
// have no shared-memory bank conflicts.
//   clk, reset_n                : clock; asynchronous active-low reset
//   in_valid_i / in_ready_o     : packet handshake
//   in_load_i, in_warp_i,
//   in_mask_i, in_addr_i,
//   in_data_i                   : packet (lane 0 at the LSBs)
//   out_valid_o / out_ready_i   : per-pass handshake (out_ready_i low = stall)
//   out_mask_o                  : lanes issued on this pass
//   out_addr_o, out_data_o,
//   out_warp_o, out_load_o      : the captured packet, held for every pass
//   out_last_o                  : final pass of the packet
//   out_pass_o                  : 0-based pass index
//   conflict_o                  : pass index is above zero
// A packet whose mask is all zeros is accepted and dropped. A new packet can
// be accepted on the cycle its predecessor's last pass is taken, so the
// output has no bubble between packets.
module bank_conflict_serializer
  import bank_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WARP_LOG  = DEF_WARP_LOG
) (
  input  logic                        clk,
  input  logic                        reset_n,

  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic                        in_load_i,
  input  logic [WARP_LOG-1:0]         in_warp_i,
  input  logic [NUM_LANES-1:0]        in_mask_i,
  input  logic [NUM_LANES*ADDR_W-1:0] in_addr_i,
  input  logic [NUM_LANES*DATA_W-1:0] in_data_i,

  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NUM_LANES-1:0]        out_mask_o,
  output logic [NUM_LANES*ADDR_W-1:0] out_addr_o,
  output logic [NUM_LANES*DATA_W-1:0] out_data_o,
  output logic [WARP_LOG-1:0]         out_warp_o,
  output logic                        out_load_o,
  output logic                        out_last_o,
  output logic [$clog2(NUM_LANES):0]  out_pass_o,
  output logic                        conflict_o
);

  localparam int PASS_W = $clog2(NUM_LANES) + 1;

  serState_t                   state;
  serState_t                   nextState;
  logic [NUM_LANES-1:0]        pending;
  logic [NUM_LANES-1:0]        selMask;
  logic [PASS_W-1:0]           passCnt;

  logic [NUM_LANES*ADDR_W-1:0] capAddr;
  logic [NUM_LANES*DATA_W-1:0] capData;
  logic [WARP_LOG-1:0]         capWarp;
  logic                        capLoad;

  logic                        fire;
  logic                        accept;
  logic                        loadNew;

  bank_lane_select #(
    .NUM_LANES (NUM_LANES),
    .NUM_BANKS (NUM_BANKS),
    .ADDR_W    (ADDR_W)
  ) u_laneSelect (
    .pending  (pending),
    .laneAddr (capAddr),
    .isLoad   (capLoad),
    .passMask (selMask)
  );

  // Handshake and pass outputs. In IDLE, pending is empty, so the gating on
  // out_valid_o only forces clean zeros.
  always_comb begin
    out_valid_o = (state == ISSUE);
    out_mask_o  = out_valid_o ? selMask : '0;
    out_last_o  = out_valid_o && ((pending & ~selMask) == '0);
    out_pass_o  = out_valid_o ? passCnt : '0;
    conflict_o  = out_valid_o && (passCnt != '0);
    fire        = out_valid_o && out_ready_i;
    in_ready_o  = (state == IDLE) || (fire && out_last_o);
    accept      = in_valid_i && in_ready_o;
    loadNew     = accept && (in_mask_i != '0);
  end

  assign out_addr_o = capAddr;
  assign out_data_o = capData;
  assign out_warp_o = capWarp;
  assign out_load_o = capLoad;

  always_comb begin
    nextState = state;
    if (loadNew) begin
      nextState = ISSUE;
    end else if (fire && out_last_o) begin
      nextState = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A reload takes priority over retiring the final pass. A zero-mask accept
  // on the last pass falls through to the retire branch and empties pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      passCnt <= '0;
    end else if (loadNew) begin
      pending <= in_mask_i;
      passCnt <= '0;
    end else if (fire) begin
      pending <= pending & ~selMask;
      passCnt <= passCnt + PASS_W'(1);
    end
  end

  // NOTE: the packet payload registers have no reset. They are only observed
  // while out_valid_o is high, which requires a fresh capture first.
  always_ff @(posedge clk) begin
    if (loadNew) begin
      capAddr <= in_addr_i;
      capData <= in_data_i;
      capWarp <= in_warp_i;
      capLoad <= in_load_i;
    end
  end

endmodule

// File: tb/tb_bank_conflict_serializer.sv
// tb_bank_conflict_serializer: directed bench for bank_conflict_serializer
// with 32 lanes and 16 banks. A queue-based model lists the passes each
// accepted packet must produce. A negedge compare process matches every
// cycle's outputs against the head of that queue. Literal checks pin both
// the model and specific DUT cycles.
module tb_bank_conflict_serializer;

  localparam int NL = 32;
  localparam int NB = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WL = 5;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic           in_load_i = 1'b0;
  logic [WL-1:0]  in_warp_i = '0;
  logic [NL-1:0]  in_mask_i = '0;
  logic [NL*AW-1:0] in_addr_i = '0;
  logic [NL*DW-1:0] in_data_i = '0;
  logic           out_valid_o;
  logic           out_ready_i = 1'b1;
  logic [NL-1:0]  out_mask_o;
  logic [NL*AW-1:0] out_addr_o;
  logic [NL*DW-1:0] out_data_o;
  logic [WL-1:0]  out_warp_o;
  logic           out_load_o;
  logic           out_last_o;
  logic [5:0]     out_pass_o;
  logic           conflict_o;

  bank_conflict_serializer #(
    .NUM_LANES (NL),
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .WARP_LOG  (WL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_load_i   (in_load_i),
    .in_warp_i   (in_warp_i),
    .in_mask_i   (in_mask_i),
    .in_addr_i   (in_addr_i),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_mask_o  (out_mask_o),
    .out_addr_o  (out_addr_o),
    .out_data_o  (out_data_o),
    .out_warp_o  (out_warp_o),
    .out_load_o  (out_load_o),
    .out_last_o  (out_last_o),
    .out_pass_o  (out_pass_o),
    .conflict_o  (conflict_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0]    mask;
    logic             last;
    int               pass;
    logic [NL*AW-1:0] addr;
    logic [NL*DW-1:0] data;
    logic [WL-1:0]    warp;
    logic             load;
  } expPass_t;

  expPass_t      expQ[$];
  logic [NL-1:0] modelMask [64];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: while lanes remain, each pending lane finds the lowest pending
  // lane in its bank (its leader). Loads issue every lane that reads its
  // leader's word. Stores issue only the leaders.
  task automatic runModel(input logic load, input logic [NL-1:0] mask,
                          input logic [NL*AW-1:0] addr, output int n);
    logic [NL-1:0] pend;
    logic [NL-1:0] m;
    logic [31:0]   ai;
    logic [31:0]   aj;
    int            lead;
    pend = mask;
    n = 0;
    while (pend != '0 && n < 64) begin
      m = '0;
      for (int i = 0; i < NL; i++) begin
        if (pend[i]) begin
          ai = addr[i*AW +: AW];
          lead = i;
          for (int j = 0; j < i; j++) begin
            aj = addr[j*AW +: AW];
            if (pend[j] && lead == i && ((aj >> 2) % NB) == ((ai >> 2) % NB)) lead = j;
          end
          aj = addr[lead*AW +: AW];
          if (load) m[i] = ((aj >> 2) == (ai >> 2));
          else      m[i] = (lead == i);
        end
      end
      pend = pend & ~m;
      modelMask[n] = m;
      n++;
    end
  endtask

  function automatic logic [NL*AW-1:0] makeAddr(input int kind);
    logic [NL*AW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) begin
      case (kind)
        0:       v[i*AW +: AW] = 32'(i * 4);
        1:       v[i*AW +: AW] = 32'h100;
        2:       v[i*AW +: AW] = 32'(i * 64);
        3:       v[i*AW +: AW] = 32'(((i * 7) % 12) * 4);
        4:       v[i*AW +: AW] = 32'h100 + 32'(i % 4);
        default: v[i*AW +: AW] = 32'(i * 8);
      endcase
    end
    return v;
  endfunction

  function automatic logic [NL*DW-1:0] makeData();
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // Called at posedge+1. Returns at posedge+1 just after the accepting edge,
  // with the packet's model passes already queued.
  task automatic sendPacket(input logic load, input logic [WL-1:0] warp, input logic [NL-1:0] mask,
                            input logic [NL*AW-1:0] addr, input logic [NL*DW-1:0] data);
    logic     accepted;
    int       n;
    expPass_t rec;
    in_load_i  = load;
    in_warp_i  = warp;
    in_mask_i  = mask;
    in_addr_i  = addr;
    in_data_i  = data;
    in_valid_i = 1'b1;
    accepted   = 1'b0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready_o === 1'b1) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    check("accept", 64'(accepted), 64'd1);
    if (accepted) begin
      runModel(load, mask, addr, n);
      for (int p = 0; p < n; p++) begin
        rec.mask = modelMask[p];
        rec.last = (p == n - 1);
        rec.pass = p;
        rec.addr = addr;
        rec.data = data;
        rec.warp = warp;
        rec.load = load;
        expQ.push_back(rec);
      end
    end
  endtask

  task automatic waitDrain();
    @(posedge clk);
    #1;
    for (int c = 0; c < 200 && expQ.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(expQ.size()), 64'd0);
  endtask

  // Per-cycle compare. The DUT must be valid exactly when the model still owes
  // passes. The head pass retires only on a cycle where out_ready_i is high.
  always @(negedge clk) begin
    if (expQ.size() == 0) begin
      check("idle_valid", 64'(out_valid_o), 64'd0);
    end else begin
      check("valid", 64'(out_valid_o), 64'd1);
      check("mask", 64'(out_mask_o), 64'(expQ[0].mask));
      check("last", 64'(out_last_o), 64'(expQ[0].last));
      check("pass", 64'(out_pass_o), 64'(expQ[0].pass));
      check("conflict", 64'(conflict_o), 64'(expQ[0].pass != 0));
      check("payload", 64'(out_addr_o == expQ[0].addr && out_data_o == expQ[0].data &&
                           out_warp_o == expQ[0].warp && out_load_o == expQ[0].load), 64'd1);
      if (out_ready_i && out_valid_o) void'(expQ.pop_front());
    end
  end

  initial begin
    int n;

    // Pin the model against hand-worked pass lists.
    runModel(1'b1, '1, makeAddr(0), n);
    check("model_lin_n", 64'(n), 64'd2);
    check("model_lin_p0", 64'(modelMask[0]), 64'h0000FFFF);
    check("model_lin_p1", 64'(modelMask[1]), 64'hFFFF0000);
    runModel(1'b0, '1, makeAddr(1), n);
    check("model_st_n", 64'(n), 64'd32);
    check("model_st_p31", 64'(modelMask[31]), 64'h80000000);
    runModel(1'b1, '1, makeAddr(5), n);
    check("model_x8_n", 64'(n), 64'd4);
    check("model_x8_p2", 64'(modelMask[2]), 64'h00FF0000);

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_ready", 64'(in_ready_o), 64'd1);
    check("rst_mask", 64'(out_mask_o), 64'd0);
    check("rst_last", 64'(out_last_o), 64'd0);
    check("rst_conflict", 64'(conflict_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Linear load, stalled 3 cycles on pass 1, then a broadcast load back to back.
    sendPacket(1'b1, 5'd3, '1, makeAddr(0), makeData());
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk);
    check("stall_mask", 64'(out_mask_o), 64'hFFFF0000);
    check("stall_pass", 64'(out_pass_o), 64'd1);
    check("stall_last", 64'(out_last_o), 64'd1);
    check("stall_conflict", 64'(conflict_o), 64'd1);
    check("stall_ready", 64'(in_ready_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    sendPacket(1'b1, 5'd7, '1, makeAddr(1), makeData());
    @(negedge clk);
    check("bcast_mask", 64'(out_mask_o), 64'hFFFFFFFF);
    check("bcast_last", 64'(out_last_o), 64'd1);
    check("bcast_conflict", 64'(conflict_o), 64'd0);
    waitDrain();

    // Same-address stores, then a load with every lane in bank 0.
    sendPacket(1'b0, 5'd1, '1, makeAddr(1), makeData());
    @(negedge clk);
    check("st_first_mask", 64'(out_mask_o), 64'h00000001);
    waitDrain();
    sendPacket(1'b1, 5'd2, '1, makeAddr(2), makeData());
    waitDrain();

    // Mixed patterns: partial masks, offset bits ignored, two lanes per bank.
    sendPacket(1'b1, 5'd4, 32'h0F0FF0F0, makeAddr(5), makeData());
    sendPacket(1'b1, 5'd5, '1, makeAddr(4), makeData());
    sendPacket(1'b1, 5'd6, 32'hA5A5A5A5, makeAddr(3), makeData());
    sendPacket(1'b0, 5'd9, 32'h00FFFF00, makeAddr(3), makeData());
    waitDrain();

    // A zero-mask packet produces nothing.
    sendPacket(1'b1, 5'd8, '0, makeAddr(0), makeData());
    repeat (4) @(posedge clk);
    #1;
    check("zero_mask_ready", 64'(in_ready_o), 64'd1);

    // Reset during pass 5 of the same-address store packet.
    sendPacket(1'b0, 5'd10, '1, makeAddr(1), makeData());
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_pass", 64'(out_pass_o), 64'd5);
    reset_n = 1'b0;
    expQ.delete();
    #1;
    check("midrst_valid", 64'(out_valid_o), 64'd0);
    check("midrst_ready", 64'(in_ready_o), 64'd1);
    check("midrst_mask", 64'(out_mask_o), 64'd0);
    check("midrst_conflict", 64'(conflict_o), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    sendPacket(1'b1, 5'd11, '1, makeAddr(0), makeData());
    @(negedge clk);
    check("post_rst_pass", 64'(out_pass_o), 64'd0);
    check("post_rst_mask", 64'(out_mask_o), 64'h0000FFFF);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_conflict_serializer.md
BANK_CONFLICT_SERIALIZER -- requirements
Module: bank_conflict_serializer

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 32, giving lanes per warp packet.
REQ-002 The block SHALL have parameter NUM_BANKS, default 16, giving shared-memory banks (power of two).
REQ-003 The block SHALL have parameter ADDR_W, default 32, giving byte-address width per lane.
REQ-004 The block SHALL have parameter DATA_W, default 32, giving store-data width per lane.
REQ-005 The block SHALL have parameter WARP_LOG, default 5, giving warp-ID width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-008 The block SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): the packet handshake.
REQ-009 The block SHALL have ports in_load_i (input, 1; 1=load, 0=store), in_warp_i (input, WARP_LOG) and in_mask_i (input, NUM_LANES): the active lanes.
REQ-010 The block SHALL have ports in_addr_i (input, NUM_LANES*ADDR_W) and in_data_i (input, NUM_LANES*DATA_W), with lane 0 at the LSBs.
REQ-011 The block SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): the per-pass handshake, with out_ready_i low meaning downstream stall.
REQ-012 The block SHALL have ports out_mask_o (output, NUM_LANES), out_addr_o and out_data_o (outputs, same widths as inputs), out_warp_o (output, WARP_LOG) and out_load_o (output, 1).
REQ-013 The block SHALL have ports out_last_o (output, 1), high on the final pass of a packet, and out_pass_o (output, $clog2(NUM_LANES)+1), the 0-based pass index.
REQ-014 The block SHALL have port conflict_o (output, 1), high when out_pass_o is greater than 0.

Function
REQ-015 The bank of a lane SHALL be addr[BANK_LOG+1:2]; its word SHALL be addr[ADDR_W-1:2]; bits [1:0] SHALL be ignored.
REQ-016 The block SHALL have two states: IDLE and ISSUE.
REQ-017 in_ready_o SHALL be 1 in IDLE, and 1 in ISSUE only when out_valid_o & out_ready_i & out_last_o.
REQ-018 On accept with a nonzero mask, the block SHALL capture the packet, set pending to in_mask_i, set the pass counter to 0 and be in ISSUE the next cycle.
REQ-019 A packet with in_mask_i==0 SHALL be accepted and dropped, with no output pass and the state unchanged.
REQ-020 In ISSUE, out_valid_o SHALL be 1, and out_addr_o, out_data_o, out_warp_o and out_load_o SHALL present the captured packet unchanged.
REQ-021 The per-bank winner SHALL be the lowest-indexed pending lane mapping to that bank.
REQ-022 For loads, out_mask_o SHALL contain every pending lane whose word equals its bank winner's word (broadcast).
REQ-023 For stores, out_mask_o SHALL contain winners only, so same-address stores serialise in ascending lane order and the highest lane writes last.
REQ-024 out_last_o SHALL be 1 when pending & ~out_mask_o == 0.
REQ-025 On out_valid_o & out_ready_i, pending SHALL clear the out_mask_o bits and the pass counter SHALL increment; if out_last_o was 1, the state SHALL go to IDLE unless a new packet is accepted in the same cycle, in which case the block SHALL reload and stay in ISSUE.
REQ-026 While out_ready_i is 0, all outputs and internal state SHALL hold stable.
REQ-027 A packet SHALL produce between 1 and NUM_LANES passes; the first pass SHALL be presented the cycle after accept.

Reset
REQ-028 Asserting reset_n low SHALL immediately force IDLE, clear pending and the pass counter, drive out_valid_o=0, out_last_o=0, conflict_o=0 and out_mask_o=0, and drive in_ready_o=1.
REQ-029 Reset asserted mid-packet SHALL discard the remaining passes; the first accept after reset release SHALL start cleanly.

Structure
REQ-030 Package bank_pkg SHALL hold the default parameters, BANK_LOG and the bank/word extraction functions.
REQ-031 Sub-module bank_lane_select SHALL implement the combinational per-bank lowest-lane priority select and broadcast match, producing out_mask_o.

Verification (NUM_LANES=32, NUM_BANKS=16)
REQ-032 Load, full mask, addr=lane*4: the bench SHALL see 2 passes, mask 0x0000FFFF then 0xFFFF0000, with out_last_o on the 2nd.
REQ-033 Load, full mask, all addr=0x100: the bench SHALL see 1 pass, mask 0xFFFFFFFF, out_last_o=1, conflict_o=0.
REQ-034 Store, full mask, all addr=0x100, and separately load with addr=lane*64: each case SHALL give 32 one-hot passes ascending lane 0..31, with out_pass_o running 0..31.
REQ-035 Out_ready_i held low 3 cycles during pass 1 of REQ-032: outputs SHALL stay stable, and mask 0xFFFF0000 SHALL complete afterwards; a back-to-back packet SHALL be accepted on the last-pass cycle with no bubble.
REQ-036 Mask=0 packet SHALL produce no out_valid_o; reset_n pulsed low during pass 5 of REQ-034 SHALL give out_valid_o=0 and in_ready_o=1 immediately.
